// File: rtl/sharpen_alu_seq.sv
// Sequences the shared DLX ALU through a 5-point Laplacian sharpen, P = 5*C - N - S - W - E, clamped to the pixel range.
// Optional macro SHARPEN_SEQ_GNT_TIMEOUT_EN: abort with err after TIMEOUT_CYC ungranted cycles.
module sharpen_alu_seq #(
  parameter int PIX_W  = 8,
  parameter int DATA_W = 32
`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  pix_c,
  input  logic [PIX_W-1:0]  pix_n,
  input  logic [PIX_W-1:0]  pix_s,
  input  logic [PIX_W-1:0]  pix_w,
  input  logic [PIX_W-1:0]  pix_e,
  output logic              busy,
  output logic              done,
  output logic [PIX_W-1:0]  pix_out,
  output logic              err,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_f,
  output logic              alu_add,
  output logic              alu_test,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovf
);

  localparam logic [2:0] F_ADD     = 3'b011;
  localparam logic [2:0] F_SUB     = 3'b010;
  localparam logic [2:0] LAST_STEP = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLAMP, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              add;
    logic [2:0]        f;
  } alu_op_t;

  state_t                   state_q;
  logic [2:0]               step_q;
  logic signed [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]        c_q, n_q, s_q, w_q, e_q;
  logic                     busy_q, done_q, err_q, req_q, add_q;
  logic [DATA_W-1:0]        a_q, b_q;
  logic [2:0]               f_q;
  logic [PIX_W-1:0]         pix_q;
  alu_op_t                  op_d, op_start_d;

`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q;
`endif

  function automatic logic [DATA_W-1:0] zext(input logic [PIX_W-1:0] p);
    return {{(DATA_W-PIX_W){1'b0}}, p};
  endfunction

  // Negative results floor at 0; anything above the pixel range saturates to all ones.
  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [DATA_W-1:0] v);
    if (v[DATA_W-1])
      return '0;
    else if (|v[DATA_W-2:PIX_W])
      return '1;
    else
      return v[PIX_W-1:0];
  endfunction

  function automatic alu_op_t op_for(input logic [2:0] step, input logic [DATA_W-1:0] acc,
                                     input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] n,
                                     input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] w,
                                     input logic [DATA_W-1:0] e);
    alu_op_t o;
    o = '0;
    case (step)
      3'd0: begin o.a = c;   o.b = c;   o.add = 1'b1; o.f = F_ADD; end
      3'd1: begin o.a = acc; o.b = acc; o.add = 1'b1; o.f = F_ADD; end
      3'd2: begin o.a = acc; o.b = c;   o.add = 1'b1; o.f = F_ADD; end
      3'd3: begin o.a = acc; o.b = n;   o.add = 1'b0; o.f = F_SUB; end
      3'd4: begin o.a = acc; o.b = s;   o.add = 1'b0; o.f = F_SUB; end
      3'd5: begin o.a = acc; o.b = w;   o.add = 1'b0; o.f = F_SUB; end
      3'd6: begin o.a = acc; o.b = e;   o.add = 1'b0; o.f = F_SUB; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next op is built from this cycle's ALU result so the registered operands are ready on the following cycle.
  always_comb begin
    op_d       = op_for(step_q + 3'd1, alu_out, c_q, n_q, s_q, w_q, e_q);
    op_start_d = op_for(3'd0, '0, zext(pix_c), zext(pix_n), zext(pix_s), zext(pix_w), zext(pix_e));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      w_q     <= '0;
      e_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      add_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      pix_q   <= '0;
`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            c_q     <= zext(pix_c);
            n_q     <= zext(pix_n);
            s_q     <= zext(pix_s);
            w_q     <= zext(pix_w);
            e_q     <= zext(pix_e);
            acc_q   <= '0;
            err_q   <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            a_q     <= op_start_d.a;
            b_q     <= op_start_d.b;
            add_q   <= op_start_d.add;
            f_q     <= op_start_d.f;
`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
            wait_q  <= '0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (alu_gnt) begin
            acc_q <= $signed(alu_out);
            if (alu_ovf)
              err_q <= 1'b1;
`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
            wait_q <= '0;
`endif
            if (step_q == LAST_STEP) begin
              req_q   <= 1'b0;
              a_q     <= '0;
              b_q     <= '0;
              add_q   <= 1'b0;
              f_q     <= '0;
              state_q <= S_CLAMP;
            end else begin
              step_q <= step_q + 3'd1;
              a_q    <= op_d.a;
              b_q    <= op_d.b;
              add_q  <= op_d.add;
              f_q    <= op_d.f;
            end
          end
`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
          else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            add_q   <= 1'b0;
            f_q     <= '0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        S_CLAMP: begin
          pix_q   <= sat_pix(acc_q);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pix_out  = pix_q;
  assign err      = err_q;
  assign alu_req  = req_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_f    = f_q;
  assign alu_add  = add_q;
  assign alu_test = 1'b0;

endmodule

// File: tb/tb_sharpen_alu_seq.sv
// Directed bench for sharpen_alu_seq: per-cycle ALU op model plus a result scoreboard checked on each done pulse.
module tb_sharpen_alu_seq;
  localparam int PIX_W  = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [PIX_W-1:0]  pix_c, pix_n, pix_s, pix_w, pix_e;
  logic              busy, done, err, alu_req, alu_gnt, alu_add, alu_test, alu_ovf;
  logic [PIX_W-1:0]  pix_out;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]        alu_f;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PIX_W:0] sb_q[$];

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared DLX ALU.
  always_comb begin
    alu_out = '0;
    if (alu_add)
      alu_out = alu_a + alu_b;
    else if (alu_f == 3'b010)
      alu_out = alu_a - alu_b;
  end

  sharpen_alu_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_c(pix_c), .pix_n(pix_n), .pix_s(pix_s), .pix_w(pix_w), .pix_e(pix_e),
    .busy(busy), .done(done), .pix_out(pix_out), .err(err),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_add(alu_add), .alu_test(alu_test),
    .alu_out(alu_out), .alu_ovf(alu_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pix(input int c, input int n, input int s, input int w, input int e);
    int v;
    v = 5 * c - n - s - w - e;
    if (v < 0) return 0;
    if (v > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":err"}, err, 0);
    check({tag, ":req"}, alu_req, 0);
    check({tag, ":a"}, alu_a, 0);
    check({tag, ":b"}, alu_b, 0);
    check({tag, ":f"}, alu_f, 0);
    check({tag, ":add"}, alu_add, 0);
    check({tag, ":test"}, alu_test, 0);
    check({tag, ":pix"}, pix_out, 0);
  endtask

  // One pixel: drives start, models the expected op on every RUN cycle, and scores the result on done.
  task automatic run_pixel(input string tag, input int c, input int n, input int s, input int w,
                           input int e, input int stall_at, input int stall_len, input int start_at,
                           input int ovf_at, input int exp_lat, input int pix_ovr, input logic exp_err);
    int k, ms;
    logic got;
    logic [DATA_W-1:0] macc, ea, eb, cz, nz, sz, wz, ez;
    logic [3:0] ef;
    logic [PIX_W:0] exp_v, got_v;
    cz = DATA_W'(c); nz = DATA_W'(n); sz = DATA_W'(s); wz = DATA_W'(w); ez = DATA_W'(e);
    pix_c = PIX_W'(c); pix_n = PIX_W'(n); pix_s = PIX_W'(s); pix_w = PIX_W'(w); pix_e = PIX_W'(e);
    exp_v = {exp_err, (pix_ovr >= 0) ? PIX_W'(pix_ovr) : PIX_W'(ref_pix(c, n, s, w, e))};
    sb_q.push_back(exp_v);
    alu_gnt = 1'b1; alu_ovf = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ":err_clear"}, err, 0);
    check({tag, ":busy"}, busy, 1);
    k = 1; ms = 0; macc = '0; got = 1'b0;
    while (!got && k < 200) begin
      alu_gnt = !(k >= stall_at && k < stall_at + stall_len);
      alu_ovf = (k == ovf_at);
      start   = (k == start_at);
      if (k == start_at) begin
        pix_c = 8'd7; pix_n = 8'd3; pix_s = 8'd3; pix_w = 8'd3; pix_e = 8'd3;
      end
      #1;
      if (done) begin
        got = 1'b1;
      end else if (ms < 7) begin
        ea = macc; eb = macc; ef = 4'b1011;
        case (ms)
          0: begin ea = cz; eb = cz; end
          1: ;
          2: eb = cz;
          3: begin eb = nz; ef = 4'b0010; end
          4: begin eb = sz; ef = 4'b0010; end
          5: begin eb = wz; ef = 4'b0010; end
          default: begin eb = ez; ef = 4'b0010; end
        endcase
        check({tag, ":run_req"}, alu_req, 1);
        check({tag, ":run_a"}, alu_a, ea);
        check({tag, ":run_b"}, alu_b, eb);
        check({tag, ":run_op"}, {alu_add, alu_f}, ef);
        if (alu_gnt) begin
          macc = ef[3] ? ea + eb : ea - eb;
          ms++;
        end
      end else begin
        check({tag, ":clamp_req"}, alu_req, 0);
        check({tag, ":clamp_op"}, {alu_add, alu_f}, 0);
        check({tag, ":clamp_busy"}, busy, 1);
      end
      if (!got) begin
        tick();
        k++;
      end
    end
    alu_gnt = 1'b1; alu_ovf = 1'b0; start = 1'b0;
    check({tag, ":done_seen"}, got, 1);
    if (got) begin
      check({tag, ":latency"}, k, exp_lat);
      check({tag, ":sb_nonempty"}, (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        got_v = {err, pix_out};
        check({tag, ":result"}, got_v, sb_q.pop_front());
      end
      check({tag, ":done_req"}, alu_req, 0);
      check({tag, ":done_busy"}, busy, 0);
      tick();
      check({tag, ":done_pulse"}, done, 0);
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; alu_gnt = 1'b0; alu_ovf = 1'b0;
    pix_c = '0; pix_n = '0; pix_s = '0; pix_w = '0; pix_e = '0;
    tick();
    tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    run_pixel("flat", 100, 100, 100, 100, 100, -1, 0, -1, -1, 9, -1, 1'b0);
    check("flat_pix", pix_out, 100);
    run_pixel("bright", 200, 50, 50, 50, 50, -1, 0, -1, -1, 9, -1, 1'b0);
    check("bright_pix", pix_out, 255);
    run_pixel("dark", 10, 200, 200, 200, 200, -1, 0, -1, -1, 9, -1, 1'b0);
    check("dark_pix", pix_out, 0);
    run_pixel("mild", 120, 100, 110, 115, 125, -1, 0, -1, -1, 9, -1, 1'b0);
    check("mild_pix", pix_out, 150);
    run_pixel("stall", 120, 100, 110, 115, 125, 3, 3, -1, -1, 12, -1, 1'b0);
    check("stall_pix", pix_out, 150);
    run_pixel("start_in_run", 120, 100, 110, 115, 125, -1, 0, 4, -1, 9, -1, 1'b0);
    check("start_in_run_pix", pix_out, 150);
    run_pixel("ovf", 100, 100, 100, 100, 100, -1, 0, -1, 4, 9, -1, 1'b1);
    run_pixel("edge255", 51, 0, 0, 0, 0, -1, 0, -1, -1, 9, -1, 1'b0);
    check("edge255_pix", pix_out, 255);
    run_pixel("edge256", 52, 4, 0, 0, 0, -1, 0, -1, -1, 9, -1, 1'b0);
    check("edge256_pix", pix_out, 255);
    run_pixel("edge_m1", 0, 1, 0, 0, 0, -1, 0, -1, -1, 9, -1, 1'b0);
    check("edge_m1_pix", pix_out, 0);
    run_pixel("edge1", 1, 4, 0, 0, 0, -1, 0, -1, -1, 9, -1, 1'b0);
    check("edge1_pix", pix_out, 1);

    // Abort at step 4 (cycle 5) with reset.
    pix_c = 8'd120; pix_n = 8'd100; pix_s = 8'd110; pix_w = 8'd115; pix_e = 8'd125;
    alu_gnt = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_pre_req", alu_req, 1);
    reset = 1'b1;
    tick();
    check_idle_zero("abort");
    reset = 1'b0;
    dn = 0;
    repeat (12) begin
      tick();
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_idle_req", alu_req, 0);
    run_pixel("after_abort", 120, 100, 110, 115, 125, -1, 0, -1, -1, 9, -1, 1'b0);
    check("after_abort_pix", pix_out, 150);

`ifdef SHARPEN_SEQ_GNT_TIMEOUT_EN
    run_pixel("gnt_timeout", 120, 100, 110, 115, 125, 1, 1000, -1, -1, 65, 0, 1'b1);
    check("gnt_timeout_pix", pix_out, 0);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
